fsm4_array: RTL and testbench



---
 rtl/fsm4_pkg.sv | 30 +++
 rtl/fsm4_chan.sv | 78 +++++++
 rtl/fsm4_array.sv | 40 ++++
 tb/tb_fsm4_array.sv | 173 +++++++++++++++++
 4 files changed

// File: rtl/fsm4_pkg.sv
// Shared definitions for the fsm4 channel array: state encoding and the
// per-channel next-state rule.
package fsm4_pkg;

    typedef enum logic [1:0] {
        S0 = 2'b00,
        S1 = 2'b01,
        S2 = 2'b10,
        S3 = 2'b11
    } fsm4_state_t;

    // Any (x,z) combination not named below leaves the state where it is.
    function automatic fsm4_state_t fsm4_next(input fsm4_state_t cur,
                                              input logic x,
                                              input logic z);
        fsm4_state_t nxt;
        nxt = cur;
        case (cur)
            S0: if (!x && z) nxt = S1; else nxt = S0;
            S1: if (x && z)  nxt = S2; else nxt = S1;
            S2: if (x)       nxt = S0;
                else if (z)  nxt = S3;
                else         nxt = S2;
            S3: if (x && !z) nxt = S2; else nxt = S3;
            default:         nxt = S0;
        endcase
        return nxt;
    endfunction

endpackage

// File: rtl/fsm4_chan.sv
// One x/z sequencing channel: state register, registered y and an optional
// saturating S2-entry counter (built only when FSM4_ARRAY_CNT_EN is defined).
module fsm4_chan
    import fsm4_pkg::*;
#(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             x,
    input  logic             z,
    input  logic             clr,
    output logic             y,
    output fsm4_state_t      state,
    output logic [CNT_W-1:0] cnt
);

    fsm4_state_t state_r;
    fsm4_state_t state_nxt_s;
    logic        y_r;

    // Next-state selection; a disabled channel ignores x and z.
    always_comb begin
        state_nxt_s = state_r;
        if (en) begin
            state_nxt_s = fsm4_next(state_r, x, z);
        end else begin
            state_nxt_s = state_r;
        end
    end

    // State and y registers; y is registered from the next state so it
    // always matches the state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= S0;
            y_r     <= 1'b0;
        end else begin
            state_r <= state_nxt_s;
            y_r     <= (state_nxt_s == S2);
        end
    end

    assign state = state_r;
    assign y     = y_r;

`ifdef FSM4_ARRAY_CNT_EN
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [CNT_W-1:0] cnt_r;
    logic             entry_s;

    assign entry_s = (state_nxt_s == S2) && (state_r != S2);

    // S2-entry counter; clr beats a simultaneous entry, and the count sticks at max.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_r <= {CNT_W{1'b0}};
        end else if (clr) begin
            cnt_r <= {CNT_W{1'b0}};
        end else if (entry_s && (cnt_r != CNT_MAX)) begin
            cnt_r <= cnt_r + CNT_ONE;
        end else begin
            cnt_r <= cnt_r;
        end
    end

    assign cnt = cnt_r;
`else
    logic unused_clr_s;

    assign unused_clr_s = clr;
    assign cnt          = {CNT_W{1'b0}};
`endif

endmodule

// File: rtl/fsm4_array.sv
// CH independent fsm4 channels with packed state/y/cnt outputs.
// Counters exist only when FSM4_ARRAY_CNT_EN is defined; otherwise cnt is 0.
module fsm4_array
    import fsm4_pkg::*;
#(
    parameter int CH    = 4,
    parameter int CNT_W = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [CH-1:0]       en,
    input  logic [CH-1:0]       x,
    input  logic [CH-1:0]       z,
    input  logic                clr,
    output logic [CH-1:0]       y,
    output logic [2*CH-1:0]     state,
    output logic [CNT_W*CH-1:0] cnt
);

    for (genvar i = 0; i < CH; i++) begin : g_chan
        fsm4_state_t chan_state_s;

        fsm4_chan #(
            .CNT_W (CNT_W)
        ) u_chan (
            .clk   (clk),
            .rst   (rst),
            .en    (en[i]),
            .x     (x[i]),
            .z     (z[i]),
            .clr   (clr),
            .y     (y[i]),
            .state (chan_state_s),
            .cnt   (cnt[CNT_W*i +: CNT_W])
        );

        assign state[2*i +: 2] = chan_state_s;
    end

endmodule

// File: tb/tb_fsm4_array.sv
// Directed bench for fsm4_array (CH=4, CNT_W=2) with a table-driven reference
// model; works with or without FSM4_ARRAY_CNT_EN.
module tb_fsm4_array;

    localparam int CH      = 4;
    localparam int CNT_W   = 2;
    localparam int CNT_MAX = 3;
`ifdef FSM4_ARRAY_CNT_EN
    localparam bit CNT_ON = 1'b1;
`else
    localparam bit CNT_ON = 1'b0;
`endif

    logic                clk = 1'b0;
    logic                rst = 1'b1;
    logic                clr = 1'b0;
    logic [CH-1:0]       en  = 4'b0000;
    logic [CH-1:0]       x   = 4'b0000;
    logic [CH-1:0]       z   = 4'b0000;
    logic [CH-1:0]       y;
    logic [2*CH-1:0]     state;
    logic [CNT_W*CH-1:0] cnt;

    fsm4_array #(.CH(CH), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .en(en), .x(x), .z(z), .clr(clr),
        .y(y), .state(state), .cnt(cnt)
    );

    always #5 clk = ~clk;

    // Successor table indexed by state*4 + x*2 + z, read straight off the
    // transition list (0..3 = S0..S3).
    int tbl [16] = '{0, 1, 0, 0,   1, 1, 1, 2,   2, 3, 0, 0,   3, 3, 2, 3};

    int m_st  [CH];
    int m_cnt [CH];

    typedef struct {
        logic       rst;
        logic       clr;
        logic [3:0] en;
        logic [3:0] x;
        logic [3:0] z;
        int         lch;
        int         lst;
        int         lcnt;
    } vec_t;

    vec_t vq [$];
    int   vec_idx = 0;
    int   checks  = 0;
    int   errors  = 0;

    // Reference model.
    always @(posedge clk) begin
        int nx;
        for (int c = 0; c < CH; c++) begin
            if (rst) begin
                m_st[c]  <= 0;
                m_cnt[c] <= 0;
            end else begin
                nx = en[c] ? tbl[m_st[c]*4 + int'(x[c])*2 + int'(z[c])] : m_st[c];
                m_st[c] <= nx;
                if (!CNT_ON || clr)
                    m_cnt[c] <= 0;
                else if (nx == 2 && m_st[c] != 2 && m_cnt[c] < CNT_MAX)
                    m_cnt[c] <= m_cnt[c] + 1;
            end
        end
    end

    // Compare DUT to model every cycle, plus the hand-computed literal for the vector.
    always @(negedge clk) begin
        if (vec_idx > 0) begin
            vec_t v;
            int   lc;
            v = vq[vec_idx-1];
            for (int c = 0; c < CH; c++) begin
                checks++;
                if (int'(state[2*c +: 2]) != m_st[c]) begin
                    errors++;
                    $display("FAIL model_state v%0d ch%0d: got %0d want %0d", vec_idx-1, c, state[2*c +: 2], m_st[c]);
                end
                checks++;
                if (y[c] != (m_st[c] == 2)) begin
                    errors++;
                    $display("FAIL model_y v%0d ch%0d: got %0b want %0b", vec_idx-1, c, y[c], m_st[c] == 2);
                end
                checks++;
                if (int'(cnt[CNT_W*c +: CNT_W]) != m_cnt[c]) begin
                    errors++;
                    $display("FAIL model_cnt v%0d ch%0d: got %0d want %0d", vec_idx-1, c, cnt[CNT_W*c +: CNT_W], m_cnt[c]);
                end
            end
            lc = CNT_ON ? v.lcnt : 0;
            checks++;
            if (int'(state[2*v.lch +: 2]) != v.lst || y[v.lch] != (v.lst == 2) ||
                int'(cnt[CNT_W*v.lch +: CNT_W]) != lc) begin
                errors++;
                $display("FAIL literal v%0d ch%0d: got st=%0d y=%0b cnt=%0d want st=%0d y=%0b cnt=%0d",
                         vec_idx-1, v.lch, state[2*v.lch +: 2], y[v.lch], cnt[CNT_W*v.lch +: CNT_W],
                         v.lst, v.lst == 2, lc);
            end
        end
    end

    task automatic add(input logic r, input logic c, input logic [3:0] e,
                       input logic [3:0] xx, input logic [3:0] zz,
                       input int ch, input int st, input int cn);
        vec_t v;
        v.rst = r; v.clr = c; v.en = e; v.x = xx; v.z = zz;
        v.lch = ch; v.lst = st; v.lcnt = cn;
        vq.push_back(v);
    endtask

    task automatic step0(input logic xb, input logic zb, input int st, input int cn);
        add(1'b0, 1'b0, 4'b0001, {3'b000, xb}, {3'b000, zb}, 0, st, cn);
    endtask

    task automatic hold3(input logic xb, input logic zb, input int st, input int cn);
        for (int k = 0; k < 3; k++) step0(xb, zb, st, cn);
    endtask

    initial begin
        // Reset and basic walk on channel 0.
        add(1'b1, 1'b0, 4'b0000, 4'b0000, 4'b0000, 0, 0, 0);
        step0(1'b0, 1'b1, 1, 0);
        step0(1'b1, 1'b1, 2, 1);
        step0(1'b0, 1'b1, 3, 1);
        step0(1'b1, 1'b0, 2, 2);
        step0(1'b1, 1'b0, 0, 2);
        // Hold coverage in every state; the S3->S2 entry below hits saturation.
        hold3(1'b0, 1'b0, 0, 2); hold3(1'b1, 1'b0, 0, 2); hold3(1'b1, 1'b1, 0, 2);
        step0(1'b0, 1'b1, 1, 2);
        hold3(1'b0, 1'b0, 1, 2); hold3(1'b0, 1'b1, 1, 2); hold3(1'b1, 1'b0, 1, 2);
        step0(1'b1, 1'b1, 2, 3);
        hold3(1'b0, 1'b0, 2, 3);
        step0(1'b0, 1'b1, 3, 3);
        hold3(1'b0, 1'b0, 3, 3); hold3(1'b0, 1'b1, 3, 3); hold3(1'b1, 1'b1, 3, 3);
        step0(1'b1, 1'b0, 2, 3);
        step0(1'b1, 1'b1, 0, 3);
        add(1'b0, 1'b1, 4'b0001, 4'b0000, 4'b0000, 0, 0, 0);
        // Enable gating: ch1 disabled, ch2 enabled, same inputs.
        add(1'b0, 1'b0, 4'b0100, 4'b0000, 4'b0110, 1, 0, 0);
        add(1'b0, 1'b0, 4'b0100, 4'b0110, 4'b0110, 2, 2, 1);
        add(1'b0, 1'b0, 4'b0000, 4'b0110, 4'b0110, 1, 0, 0);
        // Saturation on ch2: six S2<->S3 round trips.
        for (int k = 0; k < 6; k++) begin
            add(1'b0, 1'b0, 4'b0100, 4'b0000, 4'b0100, 2, 3, (k + 1 < CNT_MAX) ? k + 1 : CNT_MAX);
            add(1'b0, 1'b0, 4'b0100, 4'b0100, 4'b0000, 2, 2, (k + 2 < CNT_MAX) ? k + 2 : CNT_MAX);
        end
        add(1'b0, 1'b0, 4'b0100, 4'b0000, 4'b0100, 2, 3, 3);
        add(1'b0, 1'b1, 4'b0100, 4'b0100, 4'b0000, 2, 2, 0);
        // Spread channels over S1/S2/S3 with counts, then reset mid-operation.
        add(1'b0, 1'b0, 4'b1111, 4'b0000, 4'b1111, 2, 3, 0);
        add(1'b0, 1'b0, 4'b1111, 4'b1110, 4'b1010, 1, 2, 1);
        add(1'b0, 1'b0, 4'b1111, 4'b0000, 4'b1100, 3, 3, 1);
        add(1'b1, 1'b1, 4'b1111, 4'b1111, 4'b0000, 2, 0, 0);
        add(1'b0, 1'b0, 4'b0000, 4'b0000, 4'b0000, 1, 0, 0);

        for (int i = 0; i < vq.size(); i++) begin
            @(negedge clk);
            #1;
            rst = vq[i].rst; clr = vq[i].clr; en = vq[i].en; x = vq[i].x; z = vq[i].z;
            vec_idx = i + 1;
        end
        @(negedge clk);
        #1;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
